// File: rtl/phase_ctrl_if.sv
// Handshake bundle between the phase sequencer/memory side and phase_ctrl.
// master = the controller (drives strobes and status), slave = sequencer/memory.
interface phase_ctrl_if;
   logic [1:0]  state;
   logic [15:0] instr;
   logic        mem_ready;
   logic        en;
   logic        ir_load;
   logic        pc_inc;
   logic        alu_go;
   logic        reg_we;
   logic        mem_req;
   logic        mem_we;
   logic        addr_sel;
   logic        halted;
   logic        phase_err;
   logic        timeout_err;

   modport master (
      input  state, instr, mem_ready,
      output en, ir_load, pc_inc, alu_go, reg_we, mem_req, mem_we, addr_sel,
             halted, phase_err, timeout_err
   );

   modport slave (
      output state, instr, mem_ready,
      input  en, ir_load, pc_inc, alu_go, reg_we, mem_req, mem_we, addr_sel,
             halted, phase_err, timeout_err
   );
endinterface

// File: rtl/phase_ctrl.sv
// Fetch/decode/execute phase controller with registered datapath strobes.
// Define PHASE_CTRL_TIMEOUT_EN to enable the memory wait timeout (WAIT_MAX cycles).
module phase_ctrl #(
   parameter int WAIT_MAX = 15,
   parameter int OPW      = 4
) (
   input logic          clk,
   input logic          rst_n,
   phase_ctrl_if.master bus
);

   typedef enum logic [2:0] {IDLE, SERVE, WAIT_MEM, DONE, HALT, ERR} fsm_e;

   localparam logic [OPW-1:0] OP_NOP   = '0;
   localparam logic [OPW-1:0] OP_LOAD  = OPW'(4'h8);
   localparam logic [OPW-1:0] OP_STORE = OPW'(4'h9);
   localparam logic [OPW-1:0] OP_HALT  = OPW'(4'hF);

   fsm_e           fsm_q;
   logic [1:0]     phase_q;
   logic [OPW-1:0] opcode_q;
   logic           en_q, ir_load_q, pc_inc_q, alu_go_q, reg_we_q;
   logic           mem_req_q, mem_we_q, addr_sel_q, halted_q, phase_err_q;
   logic           exec_mem, exec_store, mem_access;
   logic           unused_instr;

   assign unused_instr = ^bus.instr[15-OPW:0];

`ifdef PHASE_CTRL_TIMEOUT_EN
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       timeout_err_q;
   assign wait_cnt_d      = wait_cnt_q + 8'd1;
   assign bus.timeout_err = timeout_err_q;
`else
   localparam int unused_wait_max = WAIT_MAX;
   assign bus.timeout_err = 1'b0;
`endif

   always_comb begin
      exec_store = (opcode_q == OP_STORE);
      exec_mem   = (opcode_q == OP_LOAD) || exec_store;
      mem_access = (phase_q == 2'b00) || ((phase_q == 2'b10) && exec_mem);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q       <= IDLE;
         phase_q     <= 2'b00;
         opcode_q    <= '0;
         en_q        <= 1'b0;
         ir_load_q   <= 1'b0;
         pc_inc_q    <= 1'b0;
         alu_go_q    <= 1'b0;
         reg_we_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         addr_sel_q  <= 1'b0;
         halted_q    <= 1'b0;
         phase_err_q <= 1'b0;
`ifdef PHASE_CTRL_TIMEOUT_EN
         wait_cnt_q    <= 8'd0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         en_q      <= 1'b0;
         ir_load_q <= 1'b0;
         pc_inc_q  <= 1'b0;
         alu_go_q  <= 1'b0;
         reg_we_q  <= 1'b0;
         case (fsm_q)
            IDLE: begin
               // While en is high the sequencer is moving to its next phase, so skip this sample.
               if (!en_q) begin
                  phase_q <= bus.state;
`ifdef PHASE_CTRL_TIMEOUT_EN
                  wait_cnt_q <= 8'd0;
`endif
                  case (bus.state)
                     2'b11: begin
                        fsm_q       <= ERR;
                        phase_err_q <= 1'b1;
                     end
                     2'b00: begin
                        fsm_q      <= SERVE;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        addr_sel_q <= 1'b0;
                     end
                     2'b10: begin
                        fsm_q <= SERVE;
                        if (exec_mem) begin
                           mem_req_q  <= 1'b1;
                           mem_we_q   <= exec_store;
                           addr_sel_q <= 1'b1;
                        end
                     end
                     default: fsm_q <= SERVE;
                  endcase
               end
            end
            SERVE, WAIT_MEM: begin
               if (mem_access) begin
                  if (bus.mem_ready) begin
                     mem_req_q  <= 1'b0;
                     mem_we_q   <= 1'b0;
                     addr_sel_q <= 1'b0;
                     if (phase_q == 2'b00) begin
                        ir_load_q <= 1'b1;
                        pc_inc_q  <= 1'b1;
                     end else if (!exec_store) begin
                        reg_we_q <= 1'b1;
                     end
                     fsm_q <= DONE;
                  end else if (fsm_q == SERVE) begin
                     fsm_q <= WAIT_MEM;
`ifdef PHASE_CTRL_TIMEOUT_EN
                  end else if (wait_cnt_d >= 8'(WAIT_MAX)) begin
                     fsm_q         <= ERR;
                     timeout_err_q <= 1'b1;
                     mem_req_q     <= 1'b0;
                     mem_we_q      <= 1'b0;
                     addr_sel_q    <= 1'b0;
                  end else begin
                     wait_cnt_q <= wait_cnt_d;
`endif
                  end
               end else if (phase_q == 2'b01) begin
                  opcode_q <= bus.instr[15 -: OPW];
                  fsm_q    <= DONE;
               end else if (opcode_q == OP_HALT) begin
                  halted_q <= 1'b1;
                  fsm_q    <= HALT;
               end else if (opcode_q == OP_NOP) begin
                  fsm_q <= DONE;
               end else begin
                  alu_go_q <= 1'b1;
                  reg_we_q <= 1'b1;
                  fsm_q    <= DONE;
               end
            end
            DONE: begin
               en_q  <= 1'b1;
               fsm_q <= IDLE;
            end
            HALT:    fsm_q <= HALT;
            ERR:     fsm_q <= ERR;
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign bus.en        = en_q;
   assign bus.ir_load   = ir_load_q;
   assign bus.pc_inc    = pc_inc_q;
   assign bus.alu_go    = alu_go_q;
   assign bus.reg_we    = reg_we_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.addr_sel  = addr_sel_q;
   assign bus.halted    = halted_q;
   assign bus.phase_err = phase_err_q;

endmodule

// File: doc/phase_ctrl.md
PHASE_CTRL -- requirements
Module: phase_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: memory wait-cycle limit before timeout (1..255).
REQ-002 SHALL have parameter OPW, default 4: opcode width, taken from instr[15:16-OPW].
REQ-003 SHALL have port clk  input  1: single clock, all logic on posedge.
REQ-004 SHALL have port rst_n  input  1: synchronous, active-low reset.
REQ-005 SHALL have port state  input  2: phase from the sequencer (00 fetch, 01 decode, 10 execute, 11 illegal).
REQ-006 SHALL have port instr  input  16: instruction word from memory.
REQ-007 SHALL have port mem_ready  input  1: memory access complete.
REQ-008 SHALL have port en  output  1: one-cycle advance pulse back to the sequencer.
REQ-009 SHALL have outputs ir_load, pc_inc, alu_go, reg_we, mem_req, mem_we, addr_sel (1 bit each): datapath strobes; addr_sel 0=PC, 1=operand.
REQ-010 SHALL have outputs halted, phase_err, timeout_err (1 bit each): sticky status.

Function
REQ-011 All outputs SHALL be registered.
REQ-012 Internal FSM SHALL have states IDLE, SERVE, WAIT_MEM, DONE, HALT, ERR.
REQ-013 IDLE: sample state; 00/01/10 -> SERVE next cycle; 11 -> ERR.
REQ-014 DONE: en=1 for exactly one cycle; state input ignored that cycle (sequencer updates on that edge); next cycle -> IDLE.
REQ-015 Fetch (00): mem_req=1, mem_we=0, addr_sel=0 from SERVE through WAIT_MEM; on the first cycle mem_ready=1, ir_load=1 and pc_inc=1 for one cycle, mem_req drops, -> DONE.
REQ-016 Decode (01): latch opcode_q <= instr opcode field, no strobes, SERVE -> DONE (2-cycle phase from IDLE to en).
REQ-017 Execute (10), opcode_q 0x0 (NOP): no strobes, -> DONE.
REQ-018 Execute, opcode_q 0xF (HALT): -> HALT; halted=1; en never asserted again.
REQ-019 Execute, opcode_q 0x8 (LOAD): mem_req=1, mem_we=0, addr_sel=1 until mem_ready; on ready, reg_we pulses 1 cycle, -> DONE.
REQ-020 Execute, opcode_q 0x9 (STORE): mem_req=1, mem_we=1, addr_sel=1 until mem_ready; no reg_we; -> DONE.
REQ-021 Execute, any other opcode: alu_go and reg_we pulse together for one cycle, -> DONE.
REQ-022 mem_ready while mem_req=0 SHALL be ignored.
REQ-023 mem_ready already high on SERVE entry SHALL complete the access in that cycle (zero wait).
REQ-024 state changing while SERVE/WAIT_MEM SHALL be ignored; the phase latched in IDLE is used.
REQ-025 ERR: phase_err=1, all strobes and en 0, held until reset.
REQ-026 At most one of ir_load/alu_go active per cycle; en never coincident with mem_req.

Reset
REQ-027 rst_n=0 at posedge SHALL force IDLE, opcode_q=0, wait counter 0, all outputs 0, mid-access included (mem_req drops next edge).
REQ-028 After rst_n rises, the first phase SHALL be sampled on the following posedge.

Configuration
REQ-029 Macro PHASE_CTRL_TIMEOUT_EN SHALL gate the wait timeout.
REQ-030 Defined: 8-bit counter increments each WAIT_MEM cycle; reaching WAIT_MAX without mem_ready -> ERR with timeout_err=1, mem_req dropped.
REQ-031 Undefined: WAIT_MEM waits indefinitely; timeout_err tied 0; counter absent.

Verification
REQ-032 Fetch, mem_ready 2 cycles after mem_req -> ir_load=pc_inc=1 one cycle, en=1 next cycle, en exactly once.
REQ-033 Full fetch/decode/execute with instr=0x3123 (ALU) -> alu_go=reg_we=1 same cycle, three en pulses total, no mem_req in execute.
REQ-034 instr=0x8000 LOAD with mem_ready 3 cycles late -> addr_sel=1, mem_we=0 throughout, reg_we on ready cycle; instr=0x9000 -> mem_we=1, no reg_we.
REQ-035 instr=0xF000 -> halted=1 after execute, en stays 0 for 50 cycles; rst_n=0 clears halted.
REQ-036 state=11 -> phase_err=1, en 0 until reset; rst_n=0 during WAIT_MEM -> all outputs 0 next edge.
REQ-037 PHASE_CTRL_TIMEOUT_EN defined, WAIT_MAX=4, mem_ready held 0 -> timeout_err=1 after 4 wait cycles; undefined -> mem_req held 100 cycles, timeout_err=0.
